cic_decim_ctrl: RTL and testbench

- Sequencing controller for the CIC decimator's integrator/comb datapath.
- Owns the oversampling select (os_sel) and the integrator reset. On every ratio change it flushes the integrators.
- Generates the decimation strobe for the comb section and masks comb warm-up outputs.
- Monitors the integrator truncation flag (flag_t) and keeps overflow statistics.

---
 rtl/cic_decim_ctrl_pkg.sv | 33 +++
 rtl/cic_decim_ctrl_ovf_mon.sv | 79 +++++++
 rtl/cic_decim_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cic_decim_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_decim_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
// Shared types and helpers for the CIC decimator sequencing controller.
//   state_t   : controller FSM states
//   OS_*      : notable oversampling-select codes
//   os_ratio  : decimation ratio minus one (R-1) for a select code, as a
//               6-bit terminal value for the phase counter
// -----------------------------------------------------------------------------
package cic_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLUSH  = 2'd1,
      SETTLE = 2'd2,
      RUN    = 2'd3
   } state_t;

   localparam logic [2:0] OS_NONE    = 3'd0;
   localparam logic [2:0] OS_MAX     = 3'd6;
   localparam logic [2:0] OS_ILLEGAL = 3'd7;

   // Code 0 means no oversampling (R=1), codes 1..6 mean R=2^code.
   // The illegal code never reaches the datapath; it maps to R=1 defensively.
   function automatic logic [5:0] os_ratio(input logic [2:0] code);
      logic [6:0] r;
      if (code > OS_MAX)
         r = 7'd1;
      else
         r = 7'd1 << code;
      return 6'(r - 7'd1);
   endfunction

endpackage

// File: rtl/cic_decim_ctrl_ovf_mon.sv
// -----------------------------------------------------------------------------
// cic_ovf_mon
// Integrator truncation-flag monitor. Registers flag_t once, detects a
// change of the toggle bit, and keeps a saturating event count plus sticky
// positive/negative overflow bits.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_active     : controller is in SETTLE or RUN
//   i_flag_t     : [1]=sign of overflowing sum, [0]=toggles once per event
//   i_clr        : clear statistics (a simultaneous event still counts)
//   o_cnt        : saturating event count
//   o_pos/o_neg  : sticky positive / negative overflow
// -----------------------------------------------------------------------------
module cic_ovf_mon
   import cic_pkg::*;
#(
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            i_active,
   input  logic [1:0]      i_flag_t,
   input  logic            i_clr,
   output logic [CNTW-1:0] o_cnt,
   output logic            o_pos,
   output logic            o_neg
);

   logic [1:0]      r_f_q;
   logic            r_f_prev;
   logic            r_prev_vld;
   logic [CNTW-1:0] r_cnt;
   logic            r_pos;
   logic            r_neg;
   logic            w_event;

   // flag_t has no reset of its own, so a comparison is only trusted once the
   // previous sample was itself taken while active.
   assign w_event = i_active & r_prev_vld & (r_f_q[0] != r_f_prev);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_f_q      <= 2'b00;
         r_f_prev   <= 1'b0;
         r_prev_vld <= 1'b0;
         r_cnt      <= '0;
         r_pos      <= 1'b0;
         r_neg      <= 1'b0;
      end else begin
         r_f_q      <= i_flag_t;
         r_f_prev   <= r_f_q[0];
         r_prev_vld <= i_active;
         if (w_event) begin
            if (i_clr) begin
               // Clear and event together: the event survives the clear.
               r_cnt <= CNTW'(1);
               r_pos <= ~r_f_q[1];
               r_neg <= r_f_q[1];
            end else begin
               if (r_cnt != '1)
                  r_cnt <= r_cnt + 1'b1;
               if (r_f_q[1])
                  r_neg <= 1'b1;
               else
                  r_pos <= 1'b1;
            end
         end else if (i_clr) begin
            r_cnt <= '0;
            r_pos <= 1'b0;
            r_neg <= 1'b0;
         end
      end
   end

   assign o_cnt = r_cnt;
   assign o_pos = r_pos;
   assign o_neg = r_neg;

endmodule

// File: rtl/cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// cic_decim_ctrl
// Sequencing controller for the CIC decimator integrator/comb datapath.
// Owns the ratio select and the integrator reset, flushes the integrators on
// every ratio change, generates the comb decimation strobe, masks the comb
// warm-up outputs and keeps integrator overflow statistics.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   enable                : run request, low forces IDLE
//   cfg_os_sel/cfg_valid  : ratio request (7 is illegal)
//   cfg_ready/cfg_err     : request accept / illegal-code pulse
//   in_valid              : one sample enters the integrators this cycle
//   os_sel, int_rst_n     : applied ratio code, integrator reset (active low)
//   dec_stb, out_valid    : comb strobe, strobe qualified by warm-up mask
//   busy                  : FLUSH or SETTLE in progress
//   flag_t, ovf_clr       : truncation flag, statistics clear
//   ovf_cnt/ovf_pos/neg   : saturating event count, sticky sign bits
// All outputs are registered.
// -----------------------------------------------------------------------------
module cic_decim_ctrl
   import cic_pkg::*;
#(
   parameter int NSTG      = 3,
   parameter int FLUSH_CYC = 4,
   parameter int CNTW      = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            enable,
   input  logic [2:0]      cfg_os_sel,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   output logic            cfg_err,
   input  logic            in_valid,
   output logic [2:0]      os_sel,
   output logic            int_rst_n,
   output logic            dec_stb,
   output logic            out_valid,
   output logic            busy,
   input  logic [1:0]      flag_t,
   input  logic            ovf_clr,
   output logic [CNTW-1:0] ovf_cnt,
   output logic            ovf_pos,
   output logic            ovf_neg
);

   localparam int WARMW = (NSTG < 2) ? 1 : $clog2(NSTG + 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [3:0]       r_fcnt;
   logic [5:0]       r_phase;
   logic [WARMW-1:0] r_warm;
   logic [2:0]       r_os_sel;
   logic             r_int_rst_n;
   logic             r_dec_stb;
   logic             r_out_valid;
   logic             r_cfg_ready;
   logic             r_cfg_err;
   logic             r_busy;

   logic             w_hs_legal;
   logic             w_hs_err;
   logic             w_active;
   logic             w_next_active;
   logic             w_phase_wrap;
   logic             w_warm_done;

   logic [3:0]       w_fcnt_next;
   logic [5:0]       w_phase_next;
   logic [WARMW-1:0] w_warm_next;
   logic [2:0]       w_os_sel_next;
   logic             w_dec_stb_next;
   logic             w_out_valid_next;

   assign w_hs_legal   = cfg_valid & r_cfg_ready & (cfg_os_sel != OS_ILLEGAL);
   assign w_hs_err     = cfg_valid & r_cfg_ready & (cfg_os_sel == OS_ILLEGAL);
   assign w_active     = (r_state == SETTLE) || (r_state == RUN);
   assign w_phase_wrap = (r_phase == os_ratio(r_os_sel));
   // Strobe currently on the output is the NSTG-th one seen in SETTLE.
   assign w_warm_done  = (r_state == SETTLE) && r_dec_stb && (r_warm == WARMW'(NSTG - 1));

   // State register and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_fcnt      <= 4'd0;
         r_phase     <= 6'd0;
         r_warm      <= '0;
         r_os_sel    <= OS_NONE;
         r_int_rst_n <= 1'b0;
         r_dec_stb   <= 1'b0;
         r_out_valid <= 1'b0;
         r_cfg_ready <= 1'b1;
         r_cfg_err   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_fcnt      <= w_fcnt_next;
         r_phase     <= w_phase_next;
         r_warm      <= w_warm_next;
         r_os_sel    <= w_os_sel_next;
         r_int_rst_n <= w_next_active;
         r_dec_stb   <= w_dec_stb_next;
         r_out_valid <= w_out_valid_next;
         r_cfg_ready <= (w_next_state == IDLE) || (w_next_state == RUN);
         r_cfg_err   <= w_hs_err;
         r_busy      <= (w_next_state == FLUSH) || (w_next_state == SETTLE);
      end
   end

   // Next-state logic; enable low overrides every other transition.
   always_comb begin
      w_next_state = r_state;
      if (!enable) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_next_state = FLUSH;
            FLUSH:   if (r_fcnt == 4'(FLUSH_CYC - 1)) w_next_state = SETTLE;
            SETTLE:  if (w_warm_done) w_next_state = RUN;
            RUN:     if (w_hs_legal) w_next_state = FLUSH;
            default: w_next_state = IDLE;
         endcase
      end
   end

   // Output / datapath next values
   always_comb begin
      w_next_active    = (w_next_state == SETTLE) || (w_next_state == RUN);
      w_os_sel_next    = w_hs_legal ? cfg_os_sel : r_os_sel;
      // Strobes only leave the controller while it stays in an active state,
      // so a flush or disable kills a strobe that would land in FLUSH/IDLE.
      w_dec_stb_next   = w_active & in_valid & w_phase_wrap & w_next_active;
      w_out_valid_next = w_dec_stb_next & (w_next_state == RUN);

      w_phase_next = r_phase;
      if (!w_active || !w_next_active)
         w_phase_next = 6'd0;
      else if (in_valid)
         w_phase_next = w_phase_wrap ? 6'd0 : r_phase + 6'd1;

      w_fcnt_next = 4'd0;
      if ((r_state == FLUSH) && (w_next_state == FLUSH))
         w_fcnt_next = r_fcnt + 4'd1;

      w_warm_next = '0;
      if ((r_state == SETTLE) && (w_next_state == SETTLE))
         w_warm_next = r_dec_stb ? r_warm + 1'b1 : r_warm;
   end

   cic_ovf_mon #(
      .CNTW (CNTW)
   ) u_ovf_mon (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_active (w_active),
      .i_flag_t (flag_t),
      .i_clr    (ovf_clr),
      .o_cnt    (ovf_cnt),
      .o_pos    (ovf_pos),
      .o_neg    (ovf_neg)
   );

   assign os_sel    = r_os_sel;
   assign int_rst_n = r_int_rst_n;
   assign dec_stb   = r_dec_stb;
   assign out_valid = r_out_valid;
   assign cfg_ready = r_cfg_ready;
   assign cfg_err   = r_cfg_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cic_decim_ctrl
// Directed sequence with randomized in_valid gating and ratio codes. The
// reference model tracks samples since the end of the flush: a strobe is due
// after every R-th accepted sample, and strobes beyond the NSTG-th are valid.
// -----------------------------------------------------------------------------
module tb_cic_decim_ctrl;

   localparam int NSTG      = 3;
   localparam int FLUSH_CYC = 4;
   localparam int CNTW      = 8;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            enable;
   logic [2:0]      cfg_os_sel;
   logic            cfg_valid;
   logic            cfg_ready;
   logic            cfg_err;
   logic            in_valid;
   logic [2:0]      os_sel;
   logic            int_rst_n;
   logic            dec_stb;
   logic            out_valid;
   logic            busy;
   logic [1:0]      flag_t;
   logic            ovf_clr;
   logic [CNTW-1:0] ovf_cnt;
   logic            ovf_pos;
   logic            ovf_neg;

   int n_tests = 0;
   int n_fail  = 0;
   int ratio   = 1;   // model decimation ratio
   int nsamp   = 0;   // samples accepted since flush ended
   int nstb    = 0;   // strobes seen since flush ended

   always #5 clk = ~clk;

   cic_decim_ctrl #(
      .NSTG      (NSTG),
      .FLUSH_CYC (FLUSH_CYC),
      .CNTW      (CNTW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .cfg_os_sel (cfg_os_sel),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_err    (cfg_err),
      .in_valid   (in_valid),
      .os_sel     (os_sel),
      .int_rst_n  (int_rst_n),
      .dec_stb    (dec_stb),
      .out_valid  (out_valid),
      .busy       (busy),
      .flag_t     (flag_t),
      .ovf_clr    (ovf_clr),
      .ovf_cnt    (ovf_cnt),
      .ovf_pos    (ovf_pos),
      .ovf_neg    (ovf_neg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset();
      chk("rst_os_sel",    32'(os_sel),    32'd0);
      chk("rst_int_rst_n", 32'(int_rst_n), 32'd0);
      chk("rst_dec_stb",   32'(dec_stb),   32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst_cfg_err",   32'(cfg_err),   32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_ovf_cnt",   32'(ovf_cnt),   32'd0);
      chk("rst_ovf_pos",   32'(ovf_pos),   32'd0);
      chk("rst_ovf_neg",   32'(ovf_neg),   32'd0);
   endtask

   // One cycle in SETTLE/RUN, checked against the sample-count model.
   task automatic step(input logic iv);
      logic exp_stb;
      in_valid = iv;
      tick();
      chk("busy", 32'(busy), 32'(nstb < NSTG));
      if (iv)
         nsamp++;
      exp_stb = iv && ((nsamp % ratio) == 0);
      if (exp_stb)
         nstb++;
      chk("dec_stb",   32'(dec_stb),   32'(exp_stb));
      chk("out_valid", 32'(out_valid), 32'(exp_stb && (nstb > NSTG)));
   endtask

   task automatic run(input int ncyc, input int pct);
      for (int i = 0; i < ncyc; i++)
         step(32'($urandom_range(99)) < pct);
   endtask

   // Counts the cycles with int_rst_n low (bounded), then arms the model.
   task automatic flush_wait(input int code);
      int n;
      n = 0;
      while (!int_rst_n && n < 20) begin
         n++;
         in_valid = 1'($urandom_range(1));
         tick();
      end
      chk("flush_len", 32'(n), 32'(FLUSH_CYC));
      chk("flush_os_sel", 32'(os_sel), 32'(code));
      ratio = 1 << code;
      nsamp = 0;
      nstb  = 0;
   endtask

   // Legal ratio handshake from RUN.
   task automatic do_cfg(input int code);
      cfg_valid  = 1'b1;
      cfg_os_sel = 3'(code);
      in_valid   = 1'b0;
      tick();
      cfg_valid  = 1'b0;
      chk("cfg_os_sel",    32'(os_sel),    32'(code));
      chk("cfg_int_rst_n", 32'(int_rst_n), 32'd0);
      chk("cfg_busy",      32'(busy),      32'd1);
      chk("cfg_ready_lo",  32'(cfg_ready), 32'd0);
      chk("cfg_dec_stb",   32'(dec_stb),   32'd0);
   endtask

   initial begin
      int code;
      reset_n    = 1'b0;
      enable     = 1'b0;
      cfg_valid  = 1'b0;
      cfg_os_sel = 3'd0;
      in_valid   = 1'b0;
      flag_t     = 2'b00;
      ovf_clr    = 1'b0;
      repeat (3) tick();
      chk_reset();

      // Start-up with ratio 1 and continuous samples.
      reset_n  = 1'b1;
      enable   = 1'b1;
      in_valid = 1'b1;
      tick();
      flush_wait(0);
      run(8, 100);
      run(40, 60);

      // Ratio 8, continuous samples.
      do_cfg(3);
      flush_wait(3);
      run(60, 100);

      // Illegal code in RUN: error pulse, nothing else moves.
      cfg_valid  = 1'b1;
      cfg_os_sel = 3'd7;
      step(1'b1);
      cfg_valid  = 1'b0;
      chk("err_pulse",  32'(cfg_err), 32'd1);
      chk("err_os_sel", 32'(os_sel),  32'd3);
      chk("err_busy",   32'(busy),    32'd0);
      chk("err_irst",   32'(int_rst_n), 32'd1);
      step(1'b1);
      chk("err_clear",  32'(cfg_err), 32'd0);
      run(40, 100);

      // Ratio 64, samples gated about 50%.
      do_cfg(6);
      flush_wait(6);
      run(700, 50);

      // Random ratios and gating.
      for (int t = 0; t < 3; t++) begin
         code = int'($urandom_range(4));
         do_cfg(code);
         flush_wait(code);
         run(150, int'($urandom_range(100, 60)));
      end

      // Overflow statistics: 300 negative events saturate the counter.
      chk("ovf_cnt_idle", 32'(ovf_cnt), 32'd0);
      for (int i = 0; i < 300; i++) begin
         flag_t = {1'b1, ~flag_t[0]};
         step(1'($urandom_range(1)));
      end
      step(1'b0);
      step(1'b0);
      chk("ovf_cnt_sat", 32'(ovf_cnt), 32'd255);
      chk("ovf_neg_set", 32'(ovf_neg), 32'd1);
      chk("ovf_pos_clr", 32'(ovf_pos), 32'd0);

      // Clear coinciding with a positive event: the event wins.
      flag_t = {1'b0, ~flag_t[0]};
      step(1'b0);
      ovf_clr = 1'b1;
      step(1'b0);
      ovf_clr = 1'b0;
      chk("ovf_clr_evt_cnt", 32'(ovf_cnt), 32'd1);
      chk("ovf_clr_evt_pos", 32'(ovf_pos), 32'd1);
      chk("ovf_clr_evt_neg", 32'(ovf_neg), 32'd0);

      // Plain clear.
      ovf_clr = 1'b1;
      step(1'b0);
      ovf_clr = 1'b0;
      chk("ovf_clr_cnt", 32'(ovf_cnt), 32'd0);
      chk("ovf_clr_pos", 32'(ovf_pos), 32'd0);
      chk("ovf_clr_neg", 32'(ovf_neg), 32'd0);

      // enable drops mid-SETTLE with a request pending: IDLE next cycle,
      // request accepted once cfg_ready returns.
      do_cfg(2);
      flush_wait(2);
      step(1'b1);
      enable     = 1'b0;
      cfg_valid  = 1'b1;
      cfg_os_sel = 3'd5;
      in_valid   = 1'b0;
      tick();
      chk("dis_int_rst_n", 32'(int_rst_n), 32'd0);
      chk("dis_busy",      32'(busy),      32'd0);
      chk("dis_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("dis_dec_stb",   32'(dec_stb),   32'd0);
      chk("dis_os_sel_old", 32'(os_sel),   32'd2);
      tick();
      cfg_valid = 1'b0;
      chk("dis_os_sel_new", 32'(os_sel),   32'd5);
      chk("dis_cfg_err",    32'(cfg_err),  32'd0);
      chk("dis_irst_idle",  32'(int_rst_n), 32'd0);
      enable = 1'b1;
      tick();
      flush_wait(5);
      run(300, 100);

      // Asynchronous reset mid-RUN, checked before the next clock edge.
      flag_t = {1'b1, ~flag_t[0]};
      step(1'b1);
      step(1'b1);
      reset_n = 1'b0;
      #2;
      chk_reset();
      tick();
      reset_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
